maze_solver: RTL and testbench

MAZE_SOLVER -- requirements
Module: maze_solver

---
 rtl/maze_pkg.sv | 62 ++++++
 rtl/maze_solver_dir_stack.sv | 52 +++++
 rtl/maze_solver.sv | 256 +++++++++++++++++++++++++
 tb/tb_maze_solver.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared types, constants and neighbour helpers for the 16x16 DFS maze solver.
package maze_pkg;

  localparam int         MAZE_DIM     = 16;
  localparam logic [3:0] MAX_COORD    = 4'd15;
  localparam logic [3:0] GOAL_X       = 4'd15;
  localparam logic [3:0] GOAL_Y       = 4'd15;
  localparam logic       CELL_FREE    = 1'b0;
  localparam logic       CELL_BLOCKED = 1'b1;

  typedef enum logic [1:0] {
    DIR_DOWN  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_UP    = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_MARK      = 3'd2,
    ST_PROBE     = 3'd3,
    ST_BACKTRACK = 3'd4,
    ST_DONE      = 3'd5,
    ST_FAIL      = 3'd6
`ifdef MAZE_PATH_REPLAY_EN
    , ST_REPLAY  = 3'd7
`endif
  } state_t;

  // Moving off the grid would wrap the 4-bit coordinate, so such neighbours are never touched.
  function automatic logic nb_in_range(input logic [3:0] x, input logic [3:0] y,
                                       input logic [1:0] d);
    logic ok;
    case (d)
      DIR_DOWN:  ok = (x != MAX_COORD);
      DIR_RIGHT: ok = (y != MAX_COORD);
      DIR_UP:    ok = (x != 4'd0);
      DIR_LEFT:  ok = (y != 4'd0);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [7:0] nb_pos(input logic [3:0] x, input logic [3:0] y,
                                        input logic [1:0] d);
    logic [7:0] p;
    case (d)
      DIR_DOWN:  p = {x + 4'd1, y};
      DIR_RIGHT: p = {x, y + 4'd1};
      DIR_UP:    p = {x - 4'd1, y};
      DIR_LEFT:  p = {x, y - 4'd1};
      default:   p = {x, y};
    endcase
    return p;
  endfunction

  function automatic logic [1:0] opposite(input logic [1:0] d);
    return d ^ 2'd2;
  endfunction

endpackage

// File: rtl/maze_solver_dir_stack.sv
// dir_stack: 256 x 2-bit LIFO of DFS move directions; sp resets asynchronously to empty.
// With MAZE_PATH_REPLAY_EN an extra indexed read port exposes entries for path replay.
module dir_stack (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       push,
  input  logic       pop,
  input  logic [1:0] din,
  output logic [1:0] dout,
  output logic [7:0] sp,
  output logic       empty
`ifdef MAZE_PATH_REPLAY_EN
  ,
  input  logic [7:0] rd_idx,
  output logic [1:0] rd_data
`endif
);

  logic [1:0] mem_r [256];
  logic [7:0] sp_r;

  // Stack pointer: clear wins, pop on empty is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_r <= 8'd0;
    end else if (clear) begin
      sp_r <= 8'd0;
    end else if (push) begin
      sp_r <= sp_r + 8'd1;
    end else if (pop && (sp_r != 8'd0)) begin
      sp_r <= sp_r - 8'd1;
    end else begin
      sp_r <= sp_r;
    end
  end

  // Entry storage; contents beyond sp are don't-care so no reset is needed.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_r[sp_r] <= din;
    end
  end

  assign dout  = mem_r[sp_r - 8'd1];
  assign sp    = sp_r;
  assign empty = (sp_r == 8'd0);
`ifdef MAZE_PATH_REPLAY_EN
  assign rd_data = mem_r[rd_idx];
`endif

endmodule

// File: rtl/maze_solver.sv
// maze_solver: depth-first search from (0,0) to (15,15) over an external 1-bit cell memory.
// Define MAZE_PATH_REPLAY_EN to stream the found path on path_valid/path_x/path_y.
module maze_solver
  import maze_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] mem_x,
  output logic [3:0] mem_y,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       mem_din,
  input  logic       mem_dout,
  output logic       done,
  output logic       fail,
  output logic       path_valid,
  output logic [3:0] path_x,
  output logic [3:0] path_y
);

  state_t     state_r, state_n;
  logic [3:0] x_r, y_r, x_n, y_n;
  logic [1:0] dir_r, dir_n;
  logic       push_s, pop_s, clear_s;
  logic [1:0] stk_dout_s;
  logic [7:0] stk_sp_s;
  logic       stk_empty_s;
  logic [7:0] nb_s, back_s, probe_s;
  logic       rd_n, wr_n, done_n, fail_n;
  logic [3:0] ax_n, ay_n;
`ifdef MAZE_PATH_REPLAY_EN
  logic [7:0] idx_r, idx_n;
  logic [1:0] rep_dir_s;
  logic       pv_n;
  logic [3:0] px_n, py_n;
`endif

  dir_stack u_stack (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_s),
    .push  (push_s),
    .pop   (pop_s),
    .din   (dir_r),
    .dout  (stk_dout_s),
    .sp    (stk_sp_s),
    .empty (stk_empty_s)
`ifdef MAZE_PATH_REPLAY_EN
    ,
    .rd_idx  (idx_r),
    .rd_data (rep_dir_s)
`endif
  );

  assign nb_s   = nb_pos(x_r, y_r, dir_r);
  assign back_s = nb_pos(x_r, y_r, opposite(stk_dout_s));

  // Next-state logic for the DFS walk.
  always_comb begin
    state_n = state_r;
    x_n     = x_r;
    y_n     = y_r;
    dir_n   = dir_r;
    push_s  = 1'b0;
    pop_s   = 1'b0;
    clear_s = 1'b0;
`ifdef MAZE_PATH_REPLAY_EN
    idx_n   = idx_r;
`endif
    case (state_r)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) begin
          state_n = ST_CHECK;
          x_n     = 4'd0;
          y_n     = 4'd0;
          dir_n   = 2'd0;
          clear_s = 1'b1;
        end else begin
          state_n = state_r;
        end
      end
      ST_CHECK: begin
        if (mem_dout == CELL_BLOCKED) begin
          state_n = ST_FAIL;
        end else begin
          state_n = ST_MARK;
        end
      end
      ST_MARK: begin
        if ((x_r == GOAL_X) && (y_r == GOAL_Y)) begin
`ifdef MAZE_PATH_REPLAY_EN
          state_n = ST_REPLAY;
          x_n     = 4'd0;
          y_n     = 4'd0;
          idx_n   = 8'd0;
`else
          state_n = ST_DONE;
`endif
        end else begin
          dir_n   = 2'd0;
          state_n = ST_PROBE;
        end
      end
      ST_PROBE: begin
        if (nb_in_range(x_r, y_r, dir_r) && (mem_dout == CELL_FREE)) begin
          // Visited marking keeps the depth below 255; the guard only protects the stack.
          push_s     = (stk_sp_s != 8'hFF);
          {x_n, y_n} = nb_s;
          state_n    = ST_MARK;
        end else if (dir_r == DIR_LEFT) begin
          state_n = ST_BACKTRACK;
        end else begin
          dir_n = dir_r + 2'd1;
        end
      end
      ST_BACKTRACK: begin
        if (stk_empty_s) begin
          state_n = ST_FAIL;
        end else begin
          pop_s      = 1'b1;
          {x_n, y_n} = back_s;
          if (stk_dout_s != DIR_LEFT) begin
            dir_n   = stk_dout_s + 2'd1;
            state_n = ST_PROBE;
          end else begin
            state_n = ST_BACKTRACK;
          end
        end
      end
`ifdef MAZE_PATH_REPLAY_EN
      ST_REPLAY: begin
        if (idx_r == stk_sp_s) begin
          state_n = ST_DONE;
        end else begin
          {x_n, y_n} = nb_pos(x_r, y_r, rep_dir_s);
          idx_n      = idx_r + 8'd1;
        end
      end
`endif
      default: state_n = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every port comes straight from a flop.
  always_comb begin
    rd_n    = 1'b0;
    wr_n    = 1'b0;
    ax_n    = 4'd0;
    ay_n    = 4'd0;
    done_n  = 1'b0;
    fail_n  = 1'b0;
    probe_s = nb_pos(x_n, y_n, dir_n);
`ifdef MAZE_PATH_REPLAY_EN
    pv_n    = 1'b0;
    px_n    = 4'd0;
    py_n    = 4'd0;
`endif
    case (state_n)
      ST_CHECK: begin
        rd_n = 1'b1;
        ax_n = x_n;
        ay_n = y_n;
      end
      ST_MARK: begin
        wr_n = 1'b1;
        ax_n = x_n;
        ay_n = y_n;
      end
      ST_PROBE: begin
        if (nb_in_range(x_n, y_n, dir_n)) begin
          rd_n         = 1'b1;
          {ax_n, ay_n} = probe_s;
        end else begin
          ax_n = x_n;
          ay_n = y_n;
        end
      end
      ST_DONE: done_n = 1'b1;
      ST_FAIL: fail_n = 1'b1;
`ifdef MAZE_PATH_REPLAY_EN
      ST_REPLAY: begin
        pv_n = 1'b1;
        px_n = x_n;
        py_n = y_n;
      end
`endif
      default: begin
        rd_n = 1'b0;
        wr_n = 1'b0;
      end
    endcase
  end

  // Solver state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      x_r     <= 4'd0;
      y_r     <= 4'd0;
      dir_r   <= 2'd0;
`ifdef MAZE_PATH_REPLAY_EN
      idx_r   <= 8'd0;
`endif
    end else begin
      state_r <= state_n;
      x_r     <= x_n;
      y_r     <= y_n;
      dir_r   <= dir_n;
`ifdef MAZE_PATH_REPLAY_EN
      idx_r   <= idx_n;
`endif
    end
  end

  // Registered memory interface and result flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
      mem_din <= 1'b0;
      mem_x   <= 4'd0;
      mem_y   <= 4'd0;
      done    <= 1'b0;
      fail    <= 1'b0;
    end else begin
      mem_rd  <= rd_n;
      mem_wr  <= wr_n;
      mem_din <= wr_n ? CELL_BLOCKED : CELL_FREE;
      mem_x   <= ax_n;
      mem_y   <= ay_n;
      done    <= done_n;
      fail    <= fail_n;
    end
  end

`ifdef MAZE_PATH_REPLAY_EN
  // Registered replay stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      path_valid <= 1'b0;
      path_x     <= 4'd0;
      path_y     <= 4'd0;
    end else begin
      path_valid <= pv_n;
      path_x     <= px_n;
      path_y     <= py_n;
    end
  end
`else
  assign path_valid = 1'b0;
  assign path_x     = 4'd0;
  assign path_y     = 4'd0;
`endif

endmodule

// File: tb/tb_maze_solver.sv
// Directed self-checking bench for maze_solver with a behavioural 16x16 cell memory.
module tb_maze_solver;
  import maze_pkg::*;

`ifdef MAZE_PATH_REPLAY_EN
  localparam int EXP_OPEN = 108;
`else
  localparam int EXP_OPEN = 77;
`endif

  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] mem_x, mem_y, path_x, path_y;
  logic       mem_rd, mem_wr, mem_din, mem_dout, done, fail, path_valid;

  logic       maze_base [16][16];
  int         wr_cnt [16][16];
  int         run_id = 0, seen_run = 0;
  int         rd_total, wr_total, edge_rd, both_hi, idle_act, bt_cycles, din_bad, pcnt;
  logic [3:0] path_xs [64];
  logic [3:0] path_ys [64];
  int         checks = 0, errors = 0;

  always #5 clk = ~clk;

  maze_solver dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_x(mem_x), .mem_y(mem_y), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_din(mem_din), .mem_dout(mem_dout),
    .done(done), .fail(fail),
    .path_valid(path_valid), .path_x(path_x), .path_y(path_y)
  );

  // A cell reads as 1 when it is a wall or has been written by the solver.
  assign mem_dout = mem_rd & (maze_base[mem_x][mem_y] | (wr_cnt[mem_x][mem_y] != 0));

  // Per-run activity monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (run_id != seen_run) begin
      seen_run = run_id;
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++) wr_cnt[i][j] = 0;
      rd_total = 0; wr_total = 0; edge_rd = 0; both_hi = 0;
      idle_act = 0; bt_cycles = 0; din_bad = 0; pcnt = 0;
    end else begin
      if (mem_rd) begin
        rd_total++;
        if (mem_x == 4'd15 || mem_y == 4'd15) edge_rd++;
      end
      if (mem_wr) begin
        wr_total++;
        wr_cnt[mem_x][mem_y]++;
        if (mem_din !== 1'b1) din_bad++;
      end
      if (mem_rd && mem_wr) both_hi++;
      if ((mem_rd || mem_wr) && (done || fail)) idle_act++;
      if (dut.state_r == ST_BACKTRACK) bt_cycles++;
      if (path_valid) begin
        if (pcnt < 64) begin
          path_xs[pcnt] = path_x;
          path_ys[pcnt] = path_y;
        end
        pcnt++;
      end
    end
  end

  task automatic clear_maze();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) maze_base[i][j] = 1'b0;
  endtask

  // New run: reset the monitor, then pulse start; returns just after the sampling edge.
  task automatic launch();
    run_id++;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_result(input int budget, output int cyc);
    cyc = 0;
    while (!(done || fail) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    clear_maze();
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_rd, mem_wr, mem_din, done, fail, path_valid, mem_x, mem_y, path_x, path_y} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rd=%0b wr=%0b done=%0b fail=%0b x=%0d y=%0d want all 0",
               mem_rd, mem_wr, done, fail, mem_x, mem_y);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_open_maze();
    int cyc, bad;
    clear_maze();
    launch();
    wait_result(400, cyc);
    checks++; if (done !== 1'b1 || fail !== 1'b0) begin errors++; $display("FAIL open_result: done=%0b fail=%0b want 1/0", done, fail); end
    checks++; if (cyc != EXP_OPEN) begin errors++; $display("FAIL open_latency: got %0d want %0d", cyc, EXP_OPEN); end
    checks++; if (wr_total != 31) begin errors++; $display("FAIL open_writes: got %0d want 31", wr_total); end
    checks++; if (bt_cycles != 0) begin errors++; $display("FAIL open_no_backtrack: got %0d want 0", bt_cycles); end
    checks++; if (both_hi != 0 || din_bad != 0) begin errors++; $display("FAIL open_mem_protocol: both=%0d din_bad=%0d want 0/0", both_hi, din_bad); end
    bad = 0;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        if (wr_cnt[x][y] != (((y == 0) || (x == 15)) ? 1 : 0)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL open_path_cells: got %0d wrong cells want 0", bad); end
`ifdef MAZE_PATH_REPLAY_EN
    bad = 0;
    for (int k = 0; k < 31; k++)
      if (path_xs[k] != ((k <= 15) ? k[3:0] : 4'd15) || path_ys[k] != ((k <= 15) ? 4'd0 : 4'(k - 15))) bad++;
    checks++; if (pcnt != 31) begin errors++; $display("FAIL replay_count: got %0d want 31", pcnt); end
    checks++; if (bad != 0) begin errors++; $display("FAIL replay_coords: got %0d wrong want 0", bad); end
`else
    checks++; if (pcnt != 0) begin errors++; $display("FAIL no_replay: got %0d path beats want 0", pcnt); end
`endif
    repeat (4) @(negedge clk);
    checks++; if (done !== 1'b1 || idle_act != 0) begin errors++; $display("FAIL open_hold: done=%0b idle_act=%0d want 1/0", done, idle_act); end
  endtask

  // Restart without clearing: (0,0) keeps its visited mark so the solve must fail.
  task automatic test_back_to_back();
    int cyc;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        if (wr_cnt[i][j] != 0) maze_base[i][j] = 1'b1;
    launch();
    checks++; if (done !== 1'b0 || fail !== 1'b0) begin errors++; $display("FAIL b2b_cleared: done=%0b fail=%0b want 0/0", done, fail); end
    wait_result(20, cyc);
    checks++; if (fail !== 1'b1 || done !== 1'b0 || cyc != 1) begin errors++; $display("FAIL b2b_fail: fail=%0b done=%0b cyc=%0d want 1/0/1", fail, done, cyc); end
    checks++; if (wr_total != 0) begin errors++; $display("FAIL b2b_no_write: got %0d want 0", wr_total); end
  endtask

  task automatic test_blocked_start();
    int cyc;
    clear_maze();
    maze_base[0][0] = 1'b1;
    launch();
    wait_result(20, cyc);
    checks++; if (fail !== 1'b1 || cyc != 1) begin errors++; $display("FAIL blocked_fail: fail=%0b cyc=%0d want 1/1", fail, cyc); end
    checks++; if (wr_total != 0 || rd_total != 1) begin errors++; $display("FAIL blocked_access: wr=%0d rd=%0d want 0/1", wr_total, rd_total); end
  endtask

  task automatic test_corner_probes();
    int cyc;
    clear_maze();
    maze_base[1][0] = 1'b1;
    maze_base[0][1] = 1'b1;
    launch();
    wait_result(50, cyc);
    checks++; if (fail !== 1'b1 || cyc != 7) begin errors++; $display("FAIL corner_fail: fail=%0b cyc=%0d want 1/7", fail, cyc); end
    checks++; if (rd_total != 3 || edge_rd != 0) begin errors++; $display("FAIL corner_reads: rd=%0d edge_rd=%0d want 3/0", rd_total, edge_rd); end
    checks++; if (wr_total != 1 || bt_cycles != 1) begin errors++; $display("FAIL corner_mark: wr=%0d bt=%0d want 1/1", wr_total, bt_cycles); end
  endtask

  task automatic test_enclosed_goal();
    int cyc, bad;
    clear_maze();
    maze_base[14][15] = 1'b1;
    maze_base[15][14] = 1'b1;
    launch();
    wait_result(5000, cyc);
    checks++; if (fail !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL enclosed_result: fail=%0b done=%0b want 1/0", fail, done); end
    checks++; if (dut.u_stack.sp !== 8'd0) begin errors++; $display("FAIL enclosed_sp: got %0d want 0", dut.u_stack.sp); end
    checks++; if (wr_total != 253) begin errors++; $display("FAIL enclosed_writes: got %0d want 253", wr_total); end
    bad = 0;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        if (wr_cnt[x][y] != ((maze_base[x][y] || (x == 15 && y == 15)) ? 0 : 1)) bad++;
    checks++; if (bad != 0 || both_hi != 0) begin errors++; $display("FAIL enclosed_once: bad=%0d both=%0d want 0/0", bad, both_hi); end
  endtask

  task automatic test_reset_mid_probe();
    int cyc;
    clear_maze();
    launch();
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({mem_rd, mem_wr, mem_din, done, fail, path_valid, mem_x, mem_y} !== 14'd0 || dut.u_stack.sp !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: rd=%0b x=%0d y=%0d sp=%0d want all 0", mem_rd, mem_x, mem_y, dut.u_stack.sp);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_maze();
    launch();
    wait_result(400, cyc);
    checks++; if (done !== 1'b1 || cyc != EXP_OPEN || wr_total != 31) begin errors++; $display("FAIL post_reset_solve: done=%0b cyc=%0d wr=%0d want 1/%0d/31", done, cyc, wr_total, EXP_OPEN); end
  endtask

  task automatic test_start_in_probe();
    int cyc;
    clear_maze();
    launch();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_result(400, cyc);
    checks++; if (done !== 1'b1 || fail !== 1'b0 || (cyc + 2) != EXP_OPEN) begin errors++; $display("FAIL start_ignored: done=%0b fail=%0b cyc=%0d want 1/0/%0d", done, fail, cyc + 2, EXP_OPEN); end
    checks++; if (wr_total != 31) begin errors++; $display("FAIL start_ignored_writes: got %0d want 31", wr_total); end
  endtask

  initial begin
    test_reset();
    test_open_maze();
    test_back_to_back();
    test_blocked_start();
    test_corner_probes();
    test_enclosed_goal();
    test_reset_mid_probe();
    test_start_in_probe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
